// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator: runtime-loadable divider stepping blink/chase/bounce/count.
// Optional PWM brightness stage when LED_PWM_EN is defined (adds the duty port).

// One LED's next-state bit and output drive; neighbours are wired by the parent.
module led_pattern_gen_lane (
  input  logic [1:0] mode,
  input  logic       dir,
  input  logic       cur,
  input  logic       lo,
  input  logic       hi,
  input  logic       lo_edge,
  input  logic       hi_edge,
  input  logic       carry_in,
  input  logic       pwm_on,
  output logic       nxt,
  output logic       led
);
  localparam logic [1:0] M_BLINK  = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;

  always_comb begin
    nxt = cur;
    case (mode)
      M_BLINK:  nxt = ~cur;
      M_CHASE:  nxt = lo;
      // plain shifts: the end lanes take zero instead of wrapping
      M_BOUNCE: nxt = dir ? (hi_edge ? 1'b0 : hi) : (lo_edge ? 1'b0 : lo);
      default:  nxt = cur ^ carry_in;
    endcase
  end

  assign led = cur & pwm_on;
endmodule

module led_pattern_gen #(
  parameter int unsigned      NUM_LEDS     = 4,
  parameter int unsigned      CNT_W        = 28,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(28'h7FFFFFF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                cfg_valid,
  input  logic [CNT_W-1:0]    cfg_half,
  output logic                cfg_ready,
`ifdef LED_PWM_EN
  input  logic [7:0]          duty,
`endif
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);
  localparam logic [1:0] M_BLINK  = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    half_q;
  logic [CNT_W-1:0]    pend_half;
  logic                pending;
  logic [1:0]          mode_q;
  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] pat_step;
  logic [NUM_LEDS-1:0] pat_nxt;
  logic [NUM_LEDS-1:0] seed;
  logic                dir;
  logic                pwm_on;

  assign tick      = ~rst && (cnt == half_q);
  assign cfg_ready = ~pending;

  assign seed = (mode == M_CHASE || mode == M_BOUNCE) ? NUM_LEDS'(1) : '0;

  // A single LED in bounce mode has nowhere to go, so it just holds.
  assign pat_nxt = (NUM_LEDS == 1 && mode_q == M_BOUNCE) ? pat : pat_step;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    localparam int LO = (i == 0) ? NUM_LEDS - 1 : i - 1;
    localparam int HI = (i == NUM_LEDS - 1) ? 0 : i + 1;
    logic carry_in;
    if (i == 0) begin : g_c0
      assign carry_in = 1'b1;
    end else begin : g_cn
      assign carry_in = &pat[i-1:0];
    end
    led_pattern_gen_lane u_lane (
      .mode     (mode_q),
      .dir      (dir),
      .cur      (pat[i]),
      .lo       (pat[LO]),
      .hi       (pat[HI]),
      .lo_edge  (i == 0),
      .hi_edge  (i == NUM_LEDS - 1),
      .carry_in (carry_in),
      .pwm_on   (pwm_on),
      .nxt      (pat_step[i]),
      .led      (led[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      half_q    <= DEFAULT_HALF;
      pend_half <= DEFAULT_HALF;
      pending   <= 1'b0;
      mode_q    <= M_BLINK;
      pat       <= '0;
      dir       <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      // pending blocks a new accept, so load and accept never collide
      if (tick && pending) begin
        half_q  <= pend_half;
        pending <= 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
        pend_half <= cfg_half;
        pending   <= 1'b1;
      end
      if (tick) begin
        if (mode != mode_q) begin
          mode_q <= mode;
          pat    <= seed;
          dir    <= 1'b0;
        end else begin
          pat <= pat_nxt;
          if (mode_q == M_BOUNCE) begin
            if (pat_nxt[NUM_LEDS-1]) dir <= 1'b1;
            if (pat_nxt[0])          dir <= 1'b0;
          end
        end
      end
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = pwm_cnt < duty;
`else
  assign pwm_on = 1'b1;
`endif

endmodule
